// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types for the tagged sort/unsort path
package sort_pkg;

    localparam int N = 7;

    typedef logic [31:0] data_t;
    typedef logic [2:0]  idx_t;

    typedef struct packed {
        logic order;
        logic idx;
        logic len;
    } err_t;

endpackage

// File: rtl/unsort_bank.sv
// rtl/unsort_bank.sv - one ping-pong bank: 7 slots, seen mask, FULL flag, sticky frame errors
module unsort_bank
    import sort_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_we,
    input  idx_t         i_idx,
    input  data_t        i_data,
    input  err_t         i_err_set,
    input  logic         i_close,
    output logic         o_full,
    output logic [N-1:0] o_seen,
    output data_t        o_data [N],
    output err_t         o_err
);

    logic         r_full;
    logic [N-1:0] r_seen;
    data_t        r_data [N];
    err_t         r_err;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_full <= 1'b0;
            r_seen <= '0;
            r_err  <= '0;
            for (int k = 0; k < N; k++) r_data[k] <= '0;
        end else begin
            // Out-of-range indices match no slot, so they never write.
            for (int k = 0; k < N; k++) begin
                if (i_we && (i_idx == idx_t'(k))) begin
                    r_data[k] <= i_data;
                    r_seen[k] <= 1'b1;
                end
            end
            r_err <= err_t'(r_err | i_err_set);
            if (i_close) r_full <= 1'b1;
        end
    end

    assign o_full = r_full;
    assign o_seen = r_seen;
    assign o_data = r_data;
    assign o_err  = r_err;

endmodule

// File: rtl/unsort_7_stream.sv
// rtl/unsort_7_stream.sv - scatters a sorted, index-tagged 7-beat stream back into original order
module unsort_7_stream
    import sort_pkg::*;
#(
    parameter int W           = 32,
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [2:0]   in_idx,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data_0,
    output logic [W-1:0] out_data_1,
    output logic [W-1:0] out_data_2,
    output logic [W-1:0] out_data_3,
    output logic [W-1:0] out_data_4,
    output logic [W-1:0] out_data_5,
    output logic [W-1:0] out_data_6,
    output logic         out_err_order,
    output logic         out_err_idx,
    output logic         out_err_len
);

    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [2:0] r_cnt;
    data_t      r_prev;

    logic         w_full [2];
    logic [N-1:0] w_seen [2];
    data_t        w_data [2][N];
    err_t         w_err  [2];

    logic       w_acc;
    logic       w_close;
    logic       w_out_fire;
    logic       w_out_en;
    logic [7:0] w_seen_ext;
    err_t       w_set_err;
    data_t      w_out_data [N];
    err_t       w_out_err;

    // Ready depends only on registered bank state, never on out_ready.
    assign in_ready   = !rst && !w_full[r_wr_ptr];
    assign w_acc      = in_valid && in_ready;
    assign w_close    = w_acc && (in_last || (r_cnt == 3'd6));
    assign w_out_en   = !rst && w_full[r_rd_ptr];
    assign w_out_fire = w_out_en && out_ready;
    assign w_seen_ext = {1'b0, w_seen[r_wr_ptr]};

    always_comb begin
        w_set_err = '0;
        if (w_acc) begin
            w_set_err.order = CHECK_ORDER && (r_cnt != 3'd0) && (in_data < r_prev);
            w_set_err.idx   = (in_idx >= 3'(N)) || w_seen_ext[in_idx];
            w_set_err.len   = w_close && !(in_last && (r_cnt == 3'd6));
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        unsort_bank u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_clr     (w_out_fire && (r_rd_ptr == 1'(b))),
            .i_we      (w_acc && (r_wr_ptr == 1'(b))),
            .i_idx     (in_idx),
            .i_data    (in_data),
            .i_err_set ((r_wr_ptr == 1'(b)) ? w_set_err : err_t'('0)),
            .i_close   (w_close && (r_wr_ptr == 1'(b))),
            .o_full    (w_full[b]),
            .o_seen    (w_seen[b]),
            .o_data    (w_data[b]),
            .o_err     (w_err[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 3'd0;
            r_prev   <= '0;
        end else begin
            if (w_acc) begin
                r_prev <= in_data;
                if (w_close) begin
                    r_cnt    <= 3'd0;
                    r_wr_ptr <= ~r_wr_ptr;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
            if (w_out_fire) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // A FREE read bank may be mid-fill, so outputs are forced to 0 unless it is FULL.
    always_comb begin
        w_out_err = w_out_en ? w_err[r_rd_ptr] : err_t'('0);
        for (int k = 0; k < N; k++) w_out_data[k] = w_out_en ? w_data[r_rd_ptr][k] : '0;
    end

    assign out_valid     = w_out_en;
    assign out_data_0    = w_out_data[0];
    assign out_data_1    = w_out_data[1];
    assign out_data_2    = w_out_data[2];
    assign out_data_3    = w_out_data[3];
    assign out_data_4    = w_out_data[4];
    assign out_data_5    = w_out_data[5];
    assign out_data_6    = w_out_data[6];
    assign out_err_order = CHECK_ORDER ? w_out_err.order : 1'b0;
    assign out_err_idx   = w_out_err.idx;
    assign out_err_len   = w_out_err.len;

endmodule

// File: tb/tb_unsort_7_stream.sv
// tb/tb_unsort_7_stream.sv - directed self-checking bench for unsort_7_stream
module tb_unsort_7_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_idx;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data_0, out_data_1, out_data_2, out_data_3, out_data_4, out_data_5, out_data_6;
    logic        out_err_order, out_err_idx, out_err_len;

    int checks = 0;
    int errors = 0;

    logic [31:0] od [7];
    assign od[0] = out_data_0;
    assign od[1] = out_data_1;
    assign od[2] = out_data_2;
    assign od[3] = out_data_3;
    assign od[4] = out_data_4;
    assign od[5] = out_data_5;
    assign od[6] = out_data_6;

    unsort_7_stream #(.W(32), .CHECK_ORDER(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_idx        (in_idx),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data_0    (out_data_0),
        .out_data_1    (out_data_1),
        .out_data_2    (out_data_2),
        .out_data_3    (out_data_3),
        .out_data_4    (out_data_4),
        .out_data_5    (out_data_5),
        .out_data_6    (out_data_6),
        .out_err_order (out_err_order),
        .out_err_idx   (out_err_idx),
        .out_err_len   (out_err_len)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat (called 1 time unit after an edge) and returns 1 unit after it is taken.
    task automatic beat(input logic [31:0] d, input int idx, input logic last);
        int wait_cnt;
        in_valid = 1'b1;
        in_data  = d;
        in_idx   = 3'(idx);
        in_last  = last;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 30) begin
            step();
            wait_cnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready=%0b required 1 for data %0d", in_ready, d);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input logic [31:0] base);
        for (int k = 0; k < 7; k++) beat(base + 32'(k), k, k == 6);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
        step(); step(); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if ({out_err_order, out_err_idx, out_err_len} !== 3'b000) begin
            errors++; $display("FAIL reset_errs: got %b want 000", {out_err_order, out_err_idx, out_err_len}); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (od[k] !== 32'd0) begin errors++; $display("FAIL reset_data%0d: got %0d want 0", k, od[k]); end
        end
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] exp [7];
        exp = '{32'd20, 32'd40, 32'd60, 32'd10, 32'd70, 32'd50, 32'd30};
        out_ready = 1'b1;
        beat(10, 3, 0); beat(20, 0, 0); beat(30, 6, 0); beat(40, 1, 0);
        beat(50, 5, 0); beat(60, 2, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
        beat(70, 4, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (od[k] !== exp[k]) begin errors++; $display("FAIL basic_data%0d: got %0d want %0d", k, od[k], exp[k]); end
        end
        checks++; if ({out_err_order, out_err_idx, out_err_len} !== 3'b000) begin
            errors++; $display("FAIL basic_errs: got %b want 000", {out_err_order, out_err_idx, out_err_len}); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_seq(1);
        send_seq(11);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); end
        checks++; if (out_data_0 !== 32'd1) begin errors++; $display("FAIL bp_hold_f1: got %0d want 1", out_data_0); end
        step(); step();
        checks++; if (out_valid !== 1'b1 || out_data_6 !== 32'd7) begin
            errors++; $display("FAIL bp_stable_f1: valid=%0b d6=%0d want 1/7", out_valid, out_data_6); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data_0 !== 32'd11) begin
            errors++; $display("FAIL bp_f2_present: valid=%0b d0=%0d want 1/11", out_valid, out_data_0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_free: got %0b want 1", in_ready); end
        send_seq(21);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full2: got %0b want 0", in_ready); end
        out_ready = 1'b1;
        checks++; if (out_data_3 !== 32'd14) begin errors++; $display("FAIL bp_f2_held: got %0d want 14", out_data_3); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data_3 !== 32'd24) begin
            errors++; $display("FAIL bp_f3: valid=%0b d3=%0d want 1/24", out_valid, out_data_3); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_order();
        out_ready = 1'b1;
        beat(5, 0, 0); beat(3, 1, 0); beat(6, 2, 0); beat(7, 3, 0);
        beat(8, 4, 0); beat(9, 5, 0); beat(10, 6, 1);
        checks++; if ({out_err_order, out_err_idx, out_err_len} !== 3'b100) begin
            errors++; $display("FAIL order_errs: got %b want 100", {out_err_order, out_err_idx, out_err_len}); end
        checks++; if (out_data_1 !== 32'd3) begin errors++; $display("FAIL order_data1: got %0d want 3", out_data_1); end
        beat(4, 0, 0); beat(4, 1, 0); beat(5, 2, 0); beat(6, 3, 0);
        beat(7, 4, 0); beat(8, 5, 0); beat(9, 6, 1);
        checks++; if (out_valid !== 1'b1 || out_err_order !== 1'b0) begin
            errors++; $display("FAIL order_clean: valid=%0b err_order=%0b want 1/0", out_valid, out_err_order); end
        step();
    endtask

    task automatic test_idx();
        logic [31:0] exp [7];
        exp = '{32'd1, 32'd2, 32'd9, 32'd10, 32'd11, 32'd0, 32'd0};
        out_ready = 1'b1;
        beat(1, 0, 0); beat(2, 1, 0); beat(8, 2, 0); beat(9, 2, 0);
        beat(10, 3, 0); beat(11, 4, 0); beat(99, 7, 1);
        checks++; if ({out_err_order, out_err_idx, out_err_len} !== 3'b010) begin
            errors++; $display("FAIL idx_errs: got %b want 010", {out_err_order, out_err_idx, out_err_len}); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (od[k] !== exp[k]) begin errors++; $display("FAIL idx_data%0d: got %0d want %0d", k, od[k], exp[k]); end
        end
        step();
    endtask

    task automatic test_len();
        out_ready = 1'b1;
        beat(1, 0, 0); beat(2, 1, 0); beat(3, 2, 0); beat(4, 3, 1);
        checks++; if ({out_err_order, out_err_idx, out_err_len} !== 3'b001) begin
            errors++; $display("FAIL len_short_errs: got %b want 001", {out_err_order, out_err_idx, out_err_len}); end
        checks++; if ({out_data_4, out_data_5, out_data_6} !== 96'd0 || out_data_3 !== 32'd4) begin
            errors++; $display("FAIL len_short_data: d3=%0d d4=%0d d5=%0d d6=%0d want 4/0/0/0",
                                out_data_3, out_data_4, out_data_5, out_data_6); end
        step();
        for (int k = 0; k < 7; k++) beat(32'd10 + 32'(k), k, 0);
        checks++; if (out_valid !== 1'b1 || out_err_len !== 1'b1 || out_data_6 !== 32'd16) begin
            errors++; $display("FAIL len_long: valid=%0b err_len=%0b d6=%0d want 1/1/16", out_valid, out_err_len, out_data_6); end
        for (int k = 0; k < 7; k++) beat(32'd20 + 32'(k), k, k == 6);
        checks++; if (out_valid !== 1'b1 || out_err_len !== 1'b0 || out_data_0 !== 32'd20 || out_data_6 !== 32'd26) begin
            errors++; $display("FAIL len_next: valid=%0b err_len=%0b d0=%0d d6=%0d want 1/0/20/26",
                                out_valid, out_err_len, out_data_0, out_data_6); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_seq(1);
        beat(50, 0, 0); beat(51, 1, 0); beat(52, 2, 0);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_comb: valid=%0b ready=%0b want 0/0", out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: valid=%0b ready=%0b want 0/0", out_valid, in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        send_seq(30);
        checks++; if (out_valid !== 1'b1 || {out_err_order, out_err_idx, out_err_len} !== 3'b000) begin
            errors++; $display("FAIL rst_fresh: valid=%0b errs=%b want 1/000", out_valid,
                                {out_err_order, out_err_idx, out_err_len}); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (od[k] !== 32'd30 + 32'(k)) begin
                errors++; $display("FAIL rst_fresh_data%0d: got %0d want %0d", k, od[k], 30 + k); end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_order();
        test_idx();
        test_len();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
